caliptra_apb_requester: RTL and testbench
=========================================

Name: caliptra_apb_requester

Overview:
APB initiator that drives the Caliptra APB responder port (PADDR/PSEL/PENABLE/PWRITE/PWDATA/PAUSER/PPROT) from a simple valid/ready command channel. It returns read data and error status on a valid/ready response channel. It sits on the FPGA side of the wrapper, between the host AXI-to-command glue and caliptra_top. It issues one transfer at a time and has a wait-state watchdog so a hung responder cannot stall the host.

Parameters:
ADDR_W, 32, APB address width (matches CALIPTRA_APB_ADDR_WIDTH)
DATA_W, 32, APB data width (matches CALIPTRA_APB_DATA_WIDTH)
USER_W, 32, PAUSER width (matches CALIPTRA_APB_USER_WIDTH)
PPROT_VAL, 3'b000, constant driven on PPROT
TIMEOUT_CYCLES, 1024, max ACCESS-phase cycles before abort; 0 disables the watchdog

Ports:
core_clk  in  1  clock
cptra_rst_b  in  1  reset, synchronous, active-low
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  target address
req_wdata  in  DATA_W  write data
req_auser  in  USER_W  PAUSER for this transfer
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_slverr  out  1  PSLVERR sampled, or timeout
rsp_timeout  out  1  watchdog abort
PADDR  out  ADDR_W  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PAUSER  out  USER_W  APB user
PPROT  out  3  tied to PPROT_VAL
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Single clock domain, core_clk. Reset is synchronous and active-low on cptra_rst_b.
- Reset values:
  - state = IDLE.
  - PSEL, PENABLE, PWRITE = 0.
  - PADDR, PWDATA, PAUSER = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_slverr = 0, rsp_timeout = 0.
  - Watchdog count = 0.
- req_ready = (state == IDLE). It is 1 in the first cycle after reset deasserts.
- FSM, all outputs registered:
  - IDLE: on req_valid && req_ready, capture write/addr/wdata/auser into the PADDR/PWRITE/PWDATA/PAUSER registers. Go to SETUP with PSEL = 1, PENABLE = 0.
  - SETUP: lasts exactly one cycle. Go to ACCESS with PENABLE = 1 and the watchdog count cleared.
  - ACCESS, PREADY = 1: capture PRDATA (only if !PWRITE, else 0) and PSLVERR. Drop PSEL and PENABLE. Go to RESP with rsp_valid = 1.
  - ACCESS, PREADY = 0: increment the watchdog count. If TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES - 1, abort:
    - drop PSEL and PENABLE;
    - rsp_timeout = 1, rsp_slverr = 1, rsp_rdata = 0;
    - go to RESP.
  - RESP: hold rsp_* stable while !rsp_ready. On rsp_ready, clear rsp_valid and rsp_timeout and go to IDLE.
- Latency, zero-wait responder:
  - command accepted at edge N;
  - PSEL = 1 at N+1, PENABLE = 1 at N+2;
  - rsp_valid = 1 at N+3.
- Back-to-back throughput: at least one PSEL = 0 cycle between transfers. There is no pipelining.
- PADDR, PWRITE, PWDATA and PAUSER hold stable from SETUP through ACCESS completion. After completion they keep their last value; they are not required to return to 0.
- PREADY and PSLVERR are ignored outside ACCESS.
- PSLVERR is sampled only on the PREADY cycle.
- A PREADY arriving on the same cycle the watchdog expires counts as a normal completion. No timeout is flagged.
- Watchdog count width is $clog2(TIMEOUT_CYCLES+1). The count saturates and never wraps.
- Reset in any state takes effect at the next edge. An in-flight transfer is dropped with no response, and PSEL/PENABLE deassert immediately.
- req_* inputs are ignored outside IDLE.
- rsp_ready is ignored when !rsp_valid.

Decomposition:
- Package caliptra_apb_req_pkg:
  - apb_req_state_e enum: IDLE, SETUP, ACCESS, RESP;
  - apb_req_t struct: write, addr, wdata, auser;
  - apb_rsp_t struct: rdata, slverr, timeout.
- One sub-module is natural: caliptra_apb_req_wdt.
  - Contains the saturating wait-state counter.
  - Inputs: clear and count enable. Output: expired.
  - Parameterised by TIMEOUT_CYCLES; expired is tied to 0 when TIMEOUT_CYCLES is 0.

Test Plan:
- Reset: hold cptra_rst_b = 0 for 3 cycles, release -> all APB outputs and rsp_* are 0, and req_ready = 1 on the first post-reset cycle.
- Zero-wait write: addr 0x3003_0000, wdata 0xDEAD_BEEF, auser 0xFFFF_FFFF, PREADY tied 1 -> PSEL one cycle before PENABLE; rsp_valid 3 cycles after accept; rsp_slverr = 0, rsp_rdata = 0.
- Wait-state read: PREADY low for 5 ACCESS cycles, PRDATA = 0x1234_5678 -> PADDR/PWRITE stable throughout; rsp_rdata = 0x1234_5678, rsp_valid 8 cycles after accept.
- Slave error plus backpressure: PSLVERR = 1 with PREADY, rsp_ready held 0 for 4 cycles -> rsp_slverr = 1 and rsp_valid held for 4 cycles; req_ready = 0 until the response is consumed.
- Timeout: TIMEOUT_CYCLES = 16, PREADY stuck 0 -> PSEL/PENABLE drop after 16 ACCESS cycles; rsp_timeout = 1, rsp_slverr = 1, rsp_rdata = 0. A following transfer completes normally.
- Reset mid-ACCESS: assert cptra_rst_b = 0 during a wait state -> PSEL = 0 at the next edge, and no rsp_valid is ever produced for the dropped transfer.

Source files
------------

// File: rtl/caliptra_apb_req_pkg.sv
// Shared types for the Caliptra APB requester.
// State encoding, command capture and response bundles.
package caliptra_apb_req_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_USER_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_req_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_USER_W-1:0] auser;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/caliptra_apb_req_wdt.sv
// Saturating ACCESS-phase wait-state counter.
// expired flags the last permitted wait cycle.
module caliptra_apb_req_wdt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam bit EN = (TIMEOUT_CYCLES != 0);
    localparam int CW = EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SAT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    // Count wait states; clear on SETUP, hold at the saturation value.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en && (count_q != SAT)) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = EN ? (count_q == LAST) : 1'b0;

endmodule

// File: rtl/caliptra_apb_requester.sv
// APB initiator for the Caliptra responder port.
// One transfer at a time, with a wait-state watchdog.
module caliptra_apb_requester
    import caliptra_apb_req_pkg::*;
#(
    parameter int         ADDR_W         = APB_ADDR_W,
    parameter int         DATA_W         = APB_DATA_W,
    parameter int         USER_W         = APB_USER_W,
    parameter logic [2:0] PPROT_VAL      = 3'b000,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic              core_clk,
    input  logic              cptra_rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [USER_W-1:0] req_auser,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic [USER_W-1:0] PAUSER,
    output logic [2:0]        PPROT,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_req_state_e state_q, state_d;
    apb_req_t       req_q, req_d;
    apb_rsp_t       rsp_q, rsp_d;
    logic           psel_q, psel_d;
    logic           pen_q, pen_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           wdt_expired;

    caliptra_apb_req_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk     (core_clk),
        .rst_b   (cptra_rst_b),
        .clear   (state_q == SETUP),
        .count_en(state_q == ACCESS && !PREADY),
        .expired (wdt_expired)
    );

    // State and registered APB/response outputs.
    always_ff @(posedge core_clk) begin
        if (!cptra_rst_b) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rsp_q       <= '0;
            psel_q      <= 1'b0;
            pen_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_q       <= rsp_d;
            psel_q      <= psel_d;
            pen_q       <= pen_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next-state and next-output logic for the transfer sequence.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_d       = rsp_q;
        psel_d      = psel_q;
        pen_d       = pen_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.write = req_write;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    req_d.auser = req_auser;
                    psel_d      = 1'b1;
                    pen_d       = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                pen_d   = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                // A PREADY on the expiry cycle wins over the watchdog.
                if (PREADY) begin
                    rsp_d.rdata   = req_q.write ? '0 : PRDATA;
                    rsp_d.slverr  = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    psel_d        = 1'b0;
                    pen_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (wdt_expired) begin
                    rsp_d.rdata   = '0;
                    rsp_d.slverr  = 1'b1;
                    rsp_d.timeout = 1'b1;
                    psel_d        = 1'b0;
                    pen_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_d.timeout = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_slverr  = rsp_q.slverr;
    assign rsp_timeout = rsp_q.timeout;
    assign PADDR       = req_q.addr;
    assign PWRITE      = req_q.write;
    assign PWDATA      = req_q.wdata;
    assign PAUSER      = req_q.auser;
    assign PSEL        = psel_q;
    assign PENABLE     = pen_q;
    assign PPROT       = PPROT_VAL;

endmodule

// File: tb/tb_caliptra_apb_requester.sv
// Self-checking bench for caliptra_apb_requester.
// Scoreboard of expected responses, popped on handshake.
module tb_caliptra_apb_requester;

    localparam int TO = 16;

    logic        core_clk = 1'b0;
    logic        cptra_rst_b = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_auser = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PAUSER;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    caliptra_apb_requester #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .core_clk   (core_clk),
        .cptra_rst_b(cptra_rst_b),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_auser  (req_auser),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PAUSER     (PAUSER),
        .PPROT      (PPROT),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] u,
                        input int waits, input logic [31:0] rd,
                        input logic se, input int bp, input bit stuck);
        int   acc;
        bit   done;
        exp_t e;
        exp_t got;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_auser = u;
        check("accept_ready", req_ready, 1);
        acc = cyc;
        e.timeout = stuck;
        e.slverr  = stuck | se;
        e.rdata   = (w || stuck) ? 32'h0 : rd;
        sb.push_back(e);
        tick();
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~a;
        req_wdata = ~d;
        req_auser = ~u;
        check("setup_psel", PSEL, 1);
        check("setup_penable", PENABLE, 0);
        check("setup_paddr", PADDR, a);
        check("setup_pwrite", PWRITE, w);
        check("setup_pwdata", PWDATA, d);
        check("setup_pauser", PAUSER, u);
        tick();
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            check("access_penable", PENABLE, 1);
            check("access_paddr", PADDR, a);
            check("access_pwrite", PWRITE, w);
            PREADY  = !stuck && (i == waits);
            PSLVERR = PREADY & se;
            PRDATA  = PREADY ? rd : ~rd;
            tick();
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            done    = rsp_valid;
        end
        check("rsp_seen", done, 1);
        check("latency", cyc - acc, stuck ? TO + 2 : waits + 3);
        check("done_psel", PSEL, 0);
        check("done_penable", PENABLE, 0);
        for (int i = 0; i < bp; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_req_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        check("hs_rsp_valid", rsp_valid, 1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            check("rsp_rdata", rsp_rdata, got.rdata);
            check("rsp_slverr", rsp_slverr, got.slverr);
            check("rsp_timeout", rsp_timeout, got.timeout);
        end else begin
            check("sb_underflow", 1, 0);
        end
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_rsp_timeout", rsp_timeout, 0);
        check("post_req_ready", req_ready, 1);
    endtask

    initial begin
        bit seen;
        cptra_rst_b = 1'b0;
        repeat (3) tick();
        cptra_rst_b = 1'b1;
        check("rst_req_ready", req_ready, 1);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_pauser", PAUSER, 0);
        check("rst_pprot", PPROT, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_slverr", rsp_slverr, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);

        xfer(1, 32'h3003_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
             0, 32'h5555_AAAA, 0, 0, 0);
        xfer(0, 32'h3003_0010, 32'h0, 32'h0000_0001,
             5, 32'h1234_5678, 0, 0, 0);
        xfer(0, 32'h3003_0020, 32'h0, 32'h0000_0002,
             0, 32'hA5A5_0001, 1, 4, 0);
        xfer(0, 32'h3003_0030, 32'h0, 32'h0000_0003,
             0, 32'h0BAD_0BAD, 0, 1, 1);
        xfer(0, 32'h3003_0040, 32'h0, 32'h0000_0004,
             2, 32'hCAFE_F00D, 0, 0, 0);
        xfer(1, 32'h3003_0050, 32'h1111_2222, 32'h0000_0005,
             14, 32'h0, 0, 0, 0);
        xfer(0, 32'h3003_0060, 32'h0, 32'h0000_0006,
             15, 32'h7777_8888, 0, 2, 0);

        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h3003_0070;
        req_auser = 32'h0000_0007;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        check("mid_penable", PENABLE, 1);
        cptra_rst_b = 1'b0;
        tick();
        check("mid_rst_psel", PSEL, 0);
        check("mid_rst_penable", PENABLE, 0);
        tick();
        cptra_rst_b = 1'b1;
        PREADY = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) seen = 1;
            tick();
        end
        PREADY = 1'b0;
        check("mid_rst_no_rsp", seen, 0);
        check("mid_rst_idle", req_ready, 1);
        check("sb_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
